synch_pipe: RTL and testbench

Parametrised successor to the single-stage DSP48A1 input/pipeline register. It implements a chain of DEPTH register stages, F bits wide, that share one clock enable. Each stage carries a valid bit, the chain can be flushed, and the block reports how many stages hold valid data. It is used for the A/B/C/D/M/P pipeline paths where more than one stage, or zero stages (bypass), is needed.

---
 rtl/synch_pipe_if.sv | 26 ++
 rtl/synch_pipe.sv | 79 +++++++
 tb/tb_synch_pipe.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/synch_pipe_if.sv
// Signal bundle for synch_pipe: stage-0 input side and last-stage output side.
// CW is derived from DEPTH here so both ends agree on the fill counter width.
interface synch_pipe_if #(
  parameter int unsigned F     = 18,
  parameter int unsigned DEPTH = 1
);
  localparam int unsigned CW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

  logic          enable;
  logic          flush;
  logic [F-1:0]  D;
  logic          d_valid;
  logic [F-1:0]  Q;
  logic          q_valid;
  logic [CW-1:0] fill_cnt;

  modport master (
    output enable, flush, D, d_valid,
    input  Q, q_valid, fill_cnt
  );

  modport slave (
    input  enable, flush, D, d_valid,
    output Q, q_valid, fill_cnt
  );
endinterface

// File: rtl/synch_pipe.sv
// DEPTH-stage enable-gated register chain with per-stage valid bits, flush and fill count.
// DEPTH = 0 degenerates to a combinational bypass.
module synch_pipe #(
  parameter int unsigned F            = 18,
  parameter int unsigned DEPTH        = 1,
  parameter bit          ZERO_INVALID = 1'b0
) (
  input logic         clk,
  input logic         reset,
  synch_pipe_if.slave bus
);
  localparam int unsigned CW = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1);

  logic [F-1:0]  q_raw;
  logic          q_vld;
  logic [CW-1:0] cnt_o;

  if (DEPTH == 0) begin : g_bypass
    logic unused_ctrl;
    assign q_raw       = bus.D;
    assign q_vld       = bus.d_valid;
    assign cnt_o       = '0;
    assign unused_ctrl = ^{clk, reset, bus.enable, bus.flush};
  end else begin : g_pipe
    logic [DEPTH-1:0][F-1:0] data_q, data_d;
    logic [DEPTH-1:0]        vld_q, vld_d;
    logic [CW-1:0]           cnt_q, cnt_d;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic [F-1:0] data_in;
      logic         vld_in;
      if (k == 0) begin : g_head
        assign data_in = bus.D;
        assign vld_in  = bus.d_valid;
      end else begin : g_body
        assign data_in = data_q[k-1];
        assign vld_in  = vld_q[k-1];
      end
      // Flush only kills valid bits; data still shifts when enabled.
      assign data_d[k] = bus.enable ? data_in : data_q[k];
      assign vld_d[k]  = bus.flush ? 1'b0 : (bus.enable ? vld_in : vld_q[k]);
    end

    always_comb begin
      cnt_d = cnt_q;
      if (bus.flush) begin
        cnt_d = '0;
      end else if (bus.enable) begin
        cnt_d = cnt_q + CW'(bus.d_valid) - CW'(vld_q[DEPTH-1]);
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        data_q <= '0;
        vld_q  <= '0;
        cnt_q  <= '0;
      end else begin
        data_q <= data_d;
        vld_q  <= vld_d;
        cnt_q  <= cnt_d;
      end
    end

    assign q_raw = data_q[DEPTH-1];
    assign q_vld = vld_q[DEPTH-1];
    assign cnt_o = cnt_q;
  end

  always_comb begin
    bus.Q = q_raw;
    if (ZERO_INVALID && !q_vld) begin
      bus.Q = '0;
    end
  end

  assign bus.q_valid  = q_vld;
  assign bus.fill_cnt = cnt_o;
endmodule

// File: tb/tb_synch_pipe.sv
// Bench for synch_pipe: one shared stimulus drives five configurations; table rows give
// expected outputs for one chosen instance, and a queue scoreboard tracks the DEPTH=3 data.
module tb_synch_pipe;
  logic        clk;
  logic        reset;
  logic        enable;
  logic        flush;
  logic        dval;
  logic [17:0] din;

  int n_checks = 0;
  int n_fail   = 0;

  synch_pipe_if #(.F(18), .DEPTH(3)) if3 ();
  synch_pipe_if #(.F(18), .DEPTH(4)) if4 ();
  synch_pipe_if #(.F(18), .DEPTH(2)) if2z ();
  synch_pipe_if #(.F(18), .DEPTH(2)) if2 ();
  synch_pipe_if #(.F(18), .DEPTH(0)) if0 ();

  assign if3.enable   = enable;
  assign if3.flush    = flush;
  assign if3.D        = din;
  assign if3.d_valid  = dval;
  assign if4.enable   = enable;
  assign if4.flush    = flush;
  assign if4.D        = din;
  assign if4.d_valid  = dval;
  assign if2z.enable  = enable;
  assign if2z.flush   = flush;
  assign if2z.D       = din;
  assign if2z.d_valid = dval;
  assign if2.enable   = enable;
  assign if2.flush    = flush;
  assign if2.D        = din;
  assign if2.d_valid  = dval;
  assign if0.enable   = enable;
  assign if0.flush    = flush;
  assign if0.D        = din;
  assign if0.d_valid  = dval;

  synch_pipe #(.F(18), .DEPTH(3), .ZERO_INVALID(1'b0)) u3 (.clk(clk), .reset(reset), .bus(if3));
  synch_pipe #(.F(18), .DEPTH(4), .ZERO_INVALID(1'b0)) u4 (.clk(clk), .reset(reset), .bus(if4));
  synch_pipe #(.F(18), .DEPTH(2), .ZERO_INVALID(1'b1)) u2z (.clk(clk), .reset(reset), .bus(if2z));
  synch_pipe #(.F(18), .DEPTH(2), .ZERO_INVALID(1'b0)) u2 (.clk(clk), .reset(reset), .bus(if2));
  synch_pipe #(.F(18), .DEPTH(0), .ZERO_INVALID(1'b0)) u0 (.clk(clk), .reset(reset), .bus(if0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // sel: 3 -> DEPTH3, 4 -> DEPTH4, 5 -> DEPTH2 zero-invalid, 2 -> DEPTH2, 0 -> bypass
  task automatic get_out(input int unsigned sel, output logic [17:0] q, output logic qv,
                         output logic [31:0] cnt);
    case (sel)
      3: begin q = if3.Q;  qv = if3.q_valid;  cnt = 32'(if3.fill_cnt);  end
      4: begin q = if4.Q;  qv = if4.q_valid;  cnt = 32'(if4.fill_cnt);  end
      5: begin q = if2z.Q; qv = if2z.q_valid; cnt = 32'(if2z.fill_cnt); end
      2: begin q = if2.Q;  qv = if2.q_valid;  cnt = 32'(if2.fill_cnt);  end
      default: begin q = if0.Q; qv = if0.q_valid; cnt = 32'(if0.fill_cnt); end
    endcase
  endtask

  typedef struct {
    logic        rst;
    logic        en;
    logic        fl;
    logic        dv;
    logic [17:0] d;
    int unsigned sel;
    logic [17:0] q;
    logic        qv;
    logic [31:0] cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic en, input logic fl, input logic dv,
                              input logic [17:0] d, input int unsigned sel,
                              input logic [17:0] q, input logic qv, input logic [31:0] cnt);
    vecs.push_back('{rst: rst, en: en, fl: fl, dv: dv, d: d, sel: sel, q: q, qv: qv, cnt: cnt});
  endfunction

  // Scoreboard for the DEPTH=3 instance: captured words must emerge in order, exactly once.
  logic [17:0] sb[$];
  logic        s_rst, s_en, s_fl, s_dv;
  logic [17:0] s_d;
  logic [17:0] sb_exp;

  always begin
    @(posedge clk);
    s_rst = reset;
    s_en  = enable;
    s_fl  = flush;
    s_dv  = dval;
    s_d   = din;
    if (s_rst || s_fl) sb.delete();
    else if (s_en && s_dv) sb.push_back(s_d);
    #1;
    if (s_en && !s_rst && !s_fl && if3.q_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("sb_empty_pop", 32'(if3.Q), 32'h0000_dead);
      end else begin
        sb_exp = sb.pop_front();
        check("sb_data", 32'(if3.Q), 32'(sb_exp));
      end
    end
    check("sb_fill", 32'(sb.size()) + 32'(if3.q_valid), 32'(if3.fill_cnt));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [17:0] q;
    logic        qv;
    logic [31:0] cnt;

    reset  = 1'b1;
    enable = 1'b0;
    flush  = 1'b0;
    dval   = 1'b0;
    din    = '0;

    // Reset, fill and stall on DEPTH=3
    add(1, 0, 0, 0, 18'h0,     3, 18'h0,     0, 0);
    add(1, 1, 0, 1, 18'h3FFFF, 3, 18'h0,     0, 0);
    add(0, 1, 0, 1, 18'h1,     3, 18'h0,     0, 1);
    add(0, 1, 0, 1, 18'h2,     3, 18'h0,     0, 2);
    add(0, 1, 0, 1, 18'h3,     3, 18'h1,     1, 3);
    add(0, 1, 0, 1, 18'h4,     3, 18'h2,     1, 3);
    add(0, 1, 0, 1, 18'h11,    3, 18'h3,     1, 3);
    add(0, 1, 0, 1, 18'h22,    3, 18'h4,     1, 3);
    add(0, 1, 0, 1, 18'h33,    3, 18'h11,    1, 3);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 1, 18'h3FFFF, 3, 18'h11, 1, 3);
    add(0, 1, 0, 1, 18'h3FFFF, 3, 18'h22,    1, 3);
    add(0, 1, 0, 0, 18'h0,     3, 18'h33,    1, 2);
    add(0, 1, 0, 0, 18'h0,     3, 18'h3FFFF, 1, 1);
    add(0, 1, 0, 0, 18'h0,     3, 18'h0,     0, 0);
    // Bubbles on DEPTH=4
    add(1, 0, 0, 0, 18'h0,     4, 18'h0,     0, 0);
    add(0, 1, 0, 1, 18'hA,     4, 18'h0,     0, 1);
    add(0, 1, 0, 0, 18'hB,     4, 18'h0,     0, 1);
    add(0, 1, 0, 1, 18'hC,     4, 18'h0,     0, 2);
    add(0, 1, 0, 1, 18'hD,     4, 18'hA,     1, 3);
    add(0, 1, 0, 0, 18'hE,     4, 18'hB,     0, 2);
    add(0, 1, 0, 0, 18'h0,     4, 18'hC,     1, 2);
    add(0, 1, 0, 0, 18'h0,     4, 18'hD,     1, 1);
    add(0, 1, 0, 0, 18'h0,     4, 18'hE,     0, 0);
    // Flush with and without enable on DEPTH=3
    add(1, 0, 0, 0, 18'h0,     3, 18'h0,     0, 0);
    add(0, 1, 0, 1, 18'h71,    3, 18'h0,     0, 1);
    add(0, 1, 0, 1, 18'h72,    3, 18'h0,     0, 2);
    add(0, 1, 0, 1, 18'h73,    3, 18'h71,    1, 3);
    add(0, 1, 1, 1, 18'h55,    3, 18'h72,    0, 0);
    add(0, 1, 0, 1, 18'h66,    3, 18'h73,    0, 1);
    add(0, 1, 0, 0, 18'h0,     3, 18'h55,    0, 1);
    add(0, 1, 0, 0, 18'h0,     3, 18'h66,    1, 1);
    add(0, 1, 0, 0, 18'h0,     3, 18'h0,     0, 0);
    add(0, 1, 0, 1, 18'h44,    3, 18'h0,     0, 1);
    add(0, 0, 1, 1, 18'h3FFFF, 3, 18'h0,     0, 0);
    add(0, 1, 0, 0, 18'h0,     3, 18'h0,     0, 0);
    add(0, 1, 0, 0, 18'h0,     3, 18'h44,    0, 0);
    // Zero-invalid gating on DEPTH=2
    add(1, 0, 0, 0, 18'h0,     5, 18'h0,     0, 0);
    add(0, 1, 0, 0, 18'h2AAAA, 5, 18'h0,     0, 0);
    add(0, 1, 0, 1, 18'h15555, 5, 18'h0,     0, 1);
    add(0, 1, 0, 0, 18'h0,     5, 18'h15555, 1, 1);
    add(0, 1, 0, 0, 18'h0,     5, 18'h0,     0, 0);
    // Reset beats flush mid-stream on DEPTH=2
    add(1, 0, 0, 0, 18'h0,     2, 18'h0,     0, 0);
    add(0, 1, 0, 1, 18'h5A,    2, 18'h0,     0, 1);
    add(0, 1, 0, 1, 18'h5B,    2, 18'h5A,    1, 2);
    add(1, 1, 1, 1, 18'h3FFFF, 2, 18'h0,     0, 0);
    add(0, 0, 0, 0, 18'h0,     2, 18'h0,     0, 0);
    add(0, 1, 0, 0, 18'h0,     2, 18'h0,     0, 0);

    foreach (vecs[i]) begin
      reset  = vecs[i].rst;
      enable = vecs[i].en;
      flush  = vecs[i].fl;
      dval   = vecs[i].dv;
      din    = vecs[i].d;
      @(posedge clk);
      #1;
      get_out(vecs[i].sel, q, qv, cnt);
      check($sformatf("v%0d_q", i),   32'(q),  32'(vecs[i].q));
      check($sformatf("v%0d_qv", i),  32'(qv), 32'(vecs[i].qv));
      check($sformatf("v%0d_cnt", i), cnt,     vecs[i].cnt);
    end

    // Bypass: outputs follow inputs in the same cycle whatever reset/enable/flush do
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      reset  = i[0];
      enable = i[1];
      flush  = i[2];
      dval   = ~i[3];
      din    = i[3] ? 18'h2ABCD : 18'h1234;
      #1;
      get_out(0, q, qv, cnt);
      check($sformatf("byp%0d_q", i),   32'(q),  i[3] ? 32'h2ABCD : 32'h1234);
      check($sformatf("byp%0d_qv", i),  32'(qv), i[3] ? 32'h0 : 32'h1);
      check($sformatf("byp%0d_cnt", i), cnt,     32'h0);
    end

    @(negedge clk);
    reset  = 1'b0;
    enable = 1'b0;
    flush  = 1'b0;
    dval   = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
